// File: rtl/sprite_dma.sv
// rtl/sprite_dma.sv - NES OAM sprite DMA engine (optional odd-cycle alignment via SPRITE_DMA_ALIGN_EN)
module sprite_dma #(
  parameter logic [15:0] TRIG_ADDR = 16'h4014,
  parameter logic [15:0] DEST_ADDR = 16'h2004
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_d,
  input  logic        cpu_rw,
  input  logic [7:0]  d_in,
  output logic        halt,
  output logic        busy,
  output logic [15:0] dma_a,
  output logic [7:0]  dma_d,
  output logic        dma_rw
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_idx;
  logic [7:0]  r_page;
  logic [7:0]  w_idx_next;
  logic [7:0]  w_page_next;
  logic        r_halt;
  logic        r_busy;
  logic [15:0] r_dma_a;
  logic [7:0]  r_dma_d;
  logic        r_dma_rw;
  logic        w_halt;
  logic        w_busy;
  logic [15:0] w_dma_a;
  logic [7:0]  w_dma_d;
  logic        w_dma_rw;
  logic        w_trig;

  assign w_trig = (cpu_rw == 1'b0) && (cpu_a == TRIG_ADDR);

`ifdef SPRITE_DMA_ALIGN_EN
  logic r_parity;

  // Free-running cycle parity; an odd HALT exit inserts one ALIGN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_parity <= 1'b0;
    else        r_parity <= ~r_parity;
  end
`endif

  // Next-state, index/page update and the bus values the next state will drive
  always_comb begin
    w_next      = r_state;
    w_idx_next  = r_idx;
    w_page_next = r_page;
    case (r_state)
      S_IDLE: begin
        if (w_trig) begin
          w_next      = S_HALT;
          w_page_next = cpu_d;
          w_idx_next  = 8'h00;
        end
      end
      S_HALT: begin
`ifdef SPRITE_DMA_ALIGN_EN
        w_next = r_parity ? S_ALIGN : S_READ;
`else
        w_next = S_READ;
`endif
      end
      S_ALIGN: w_next = S_READ;
      S_READ:  w_next = S_WRITE;
      S_WRITE: begin
        w_idx_next = r_idx + 8'h01;
        w_next     = (r_idx == 8'hFF) ? S_IDLE : S_READ;
      end
      default: w_next = S_IDLE;
    endcase

    w_halt   = (w_next != S_IDLE);
    w_busy   = (w_next != S_IDLE);
    w_dma_rw = (w_next != S_WRITE);
    w_dma_a  = 16'h0000;
    w_dma_d  = r_dma_d;
    case (w_next)
      S_HALT, S_ALIGN: w_dma_a = DEST_ADDR;
      S_READ:          w_dma_a = {w_page_next, w_idx_next};
      S_WRITE: begin
        w_dma_a = DEST_ADDR;
        w_dma_d = d_in;
      end
      default: begin
        w_dma_a = 16'h0000;
        w_dma_d = 8'h00;
      end
    endcase
  end

  // State, index, page and registered bus outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= 8'h00;
      r_page   <= 8'h00;
      r_halt   <= 1'b0;
      r_busy   <= 1'b0;
      r_dma_a  <= 16'h0000;
      r_dma_d  <= 8'h00;
      r_dma_rw <= 1'b1;
    end else begin
      r_state  <= w_next;
      r_idx    <= w_idx_next;
      r_page   <= w_page_next;
      r_halt   <= w_halt;
      r_busy   <= w_busy;
      r_dma_a  <= w_dma_a;
      r_dma_d  <= w_dma_d;
      r_dma_rw <= w_dma_rw;
    end
  end

  assign halt   = r_halt;
  assign busy   = r_busy;
  assign dma_a  = r_dma_a;
  assign dma_d  = r_dma_d;
  assign dma_rw = r_dma_rw;

endmodule
